// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper phase sequencer: FSM states,
// coil phase table, motor command bit positions and the speed-to-period helper.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned DIV_W = 24;

  localparam int unsigned CMD_RUN_BIT = 0;
  localparam int unsigned CMD_DIR_BIT = 1;
  localparam int unsigned CMD_SPD_LSB = 2;
  localparam int unsigned CMD_SPD_MSB = 3;

  // Half-step coil sequence, index 0 in the low slot; odd entries are the two-coil full steps.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic logic [DIV_W-1:0] step_period(input logic [DIV_W-1:0] base,
                                                   input logic [1:0]       speed);
    return base << (2'd3 - speed);
  endfunction

endpackage

// File: rtl/stepper_phase_sequencer_if.sv
// Bundle between the motor PIO export and the stepper sequencer.
interface stepper_phase_sequencer_if;
  import stepper_pkg::*;

  // motor_cmd is a level sampled every clock; step_pulse is a one-cycle strobe
  // with no back-pressure, so there is no valid/ready pair on this bundle.
  logic [3:0]  motor_cmd;
  logic [3:0]  coil_out;
  logic        step_pulse;
  logic [15:0] position;
  logic        busy;
  state_e      dbg_state;

  modport master (
    output motor_cmd,
    input  coil_out, step_pulse, position, busy, dbg_state
  );

  modport slave (
    input  motor_cmd,
    output coil_out, step_pulse, position, busy, dbg_state
  );

endinterface

// File: rtl/stepper_rate_div.sv
// Programmable step-rate divider: counts 0..period-1 and flags the last count.
module stepper_rate_div
  import stepper_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] period_i,
  input  logic             clear_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == (period_i - DIV_W'(1)));

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stepper_phase_sequencer.sv
// Turns the PIO motor command word into timed unipolar coil patterns with a
// signed position count and a timed hold before the coils are released.
module stepper_phase_sequencer
  import stepper_pkg::*;
#(
  parameter int unsigned BASE_DIV   = 50000,
  parameter int unsigned HOLD_TICKS = 200,
  parameter int unsigned FULL_STEP  = 0
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  stepper_phase_sequencer_if.slave  pio
);

  localparam int unsigned HOLD_W    = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;
  localparam int unsigned HOLD_LASTV = (HOLD_TICKS == 0) ? 0 : HOLD_TICKS - 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LASTV);
  localparam logic [2:0] PH_INC = (FULL_STEP != 0) ? 3'd2 : 3'd1;

  state_e             state_q, state_d;
  logic [2:0]         phase_q, phase_d;
  logic [15:0]        pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [1:0]         speed_q, speed_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [3:0]         coil_q, coil_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;

  logic               div_clear;
  logic               tick;
  logic               cmd_run;
  logic               cmd_dir;
  logic [1:0]         cmd_speed;

  assign cmd_run   = pio.motor_cmd[CMD_RUN_BIT];
  assign cmd_dir   = pio.motor_cmd[CMD_DIR_BIT];
  assign cmd_speed = pio.motor_cmd[CMD_SPD_MSB:CMD_SPD_LSB];

  stepper_rate_div u_rate_div (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .period_i (step_period(DIV_W'(BASE_DIV), speed_q)),
    .clear_i  (div_clear),
    .tick_o   (tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    speed_d   = speed_q;
    hold_d    = hold_q;
    step_d    = 1'b0;
    div_clear = 1'b0;

    case (state_q)
      IDLE: begin
        div_clear = 1'b1;
        if (cmd_run) begin
          state_d = RUN;
          dir_d   = cmd_dir;
          speed_d = cmd_speed;
          hold_d  = '0;
          // Full-step mode only ever sits on odd (two-coil) entries.
          if (FULL_STEP != 0) begin
            phase_d[0] = 1'b1;
          end
        end
      end
      RUN: begin
        if (!cmd_run) begin
          // Dropping run wins over a coincident tick: no step is taken.
          state_d   = HOLD;
          div_clear = 1'b1;
          hold_d    = '0;
        end else if (tick) begin
          step_d  = 1'b1;
          phase_d = dir_q ? (phase_q + PH_INC) : (phase_q - PH_INC);
          pos_d   = dir_q ? (pos_q + 16'd1) : (pos_q - 16'd1);
          dir_d   = cmd_dir;
          speed_d = cmd_speed;
        end
      end
      HOLD: begin
        if (cmd_run) begin
          state_d   = RUN;
          div_clear = 1'b1;
          hold_d    = '0;
          dir_d     = cmd_dir;
          speed_d   = cmd_speed;
        end else if (HOLD_TICKS == 0) begin
          state_d   = IDLE;
          div_clear = 1'b1;
        end else if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d   = IDLE;
            div_clear = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        div_clear = 1'b1;
      end
    endcase

    coil_d = (state_d == IDLE) ? 4'b0000 : PHASE_TABLE[phase_d];
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      speed_q <= '0;
      hold_q  <= '0;
      coil_q  <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      hold_q  <= hold_d;
      coil_q  <= coil_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  assign pio.coil_out   = coil_q;
  assign pio.step_pulse = step_q;
  assign pio.position   = pos_q;
  assign pio.busy       = busy_q;
  assign pio.dbg_state  = state_q;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Bench for stepper_phase_sequencer: a half-step instance (BASE_DIV=4, HOLD_TICKS=2)
// and a full-step instance (BASE_DIV=1, HOLD_TICKS=0) used for the position wrap.
module tb_stepper_phase_sequencer;
  import stepper_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stepper_phase_sequencer_if b1 ();
  stepper_phase_sequencer_if b2 ();

  stepper_phase_sequencer #(.BASE_DIV(4), .HOLD_TICKS(2), .FULL_STEP(0)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pio           (b1)
  );

  stepper_phase_sequencer #(.BASE_DIV(1), .HOLD_TICKS(0), .FULL_STEP(1)) dut_fs (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pio           (b2)
  );

  // ---------------- clock counter / bookkeeping ----------------
  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected step entry: {absolute cycle, coil pattern, position}
  logic [51:0] exp_q[$];
  logic [51:0] exp2_q[$];
  logic [51:0] e1, e2;

  function automatic logic [51:0] ent(input int c, input logic [3:0] coil, input logic [15:0] pos);
    return {32'(c), coil, pos};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (b1.step_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL hs_step_unexpected: got step coil=%b pos=%0h expected no step (cycle %0d)",
                 b1.coil_out, b1.position, cyc);
      end else begin
        e1 = exp_q.pop_front();
        check("hs_step_cycle", 32'(cyc), e1[51:20]);
        check("hs_step_coil", 32'(b1.coil_out), 32'(e1[19:16]));
        check("hs_step_pos", 32'(b1.position), 32'(e1[15:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (b2.step_pulse === 1'b1) begin
      if (exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fs_step_unexpected: got step coil=%b pos=%0h expected no step (cycle %0d)",
                 b2.coil_out, b2.position, cyc);
      end else begin
        e2 = exp2_q.pop_front();
        check("fs_step_cycle", 32'(cyc), e2[51:20]);
        check("fs_step_coil", 32'(b2.coil_out), 32'(e2[19:16]));
        check("fs_step_pos", 32'(b2.position), 32'(e2[15:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  int n, m, x, r, w, s, errs;
  logic [3:0] fs_seq[4];

  initial begin
    fs_seq = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    b1.motor_cmd = 4'b0000;
    b2.motor_cmd = 4'b0000;

    // Reset state
    @(negedge clk);
    check("rst_coil", 32'(b1.coil_out), 32'h0);
    check("rst_step", 32'(b1.step_pulse), 32'h0);
    check("rst_pos", 32'(b1.position), 32'h0);
    check("rst_busy", 32'(b1.busy), 32'h0);
    rst_n = 1'b1;

    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b1.coil_out !== 4'b0000 || b1.busy !== 1'b0 || b2.coil_out !== 4'b0000) errs++;
    end
    check("idle_quiet_100", 32'(errs), 32'h0);

    // Forward run at speed 3: P = 4
    n = cyc;
    exp_q.push_back(ent(n + 5,  4'b0011, 16'd1));
    exp_q.push_back(ent(n + 9,  4'b0010, 16'd2));
    exp_q.push_back(ent(n + 13, 4'b0110, 16'd3));
    exp_q.push_back(ent(n + 17, 4'b0100, 16'd4));
    exp_q.push_back(ent(n + 21, 4'b1100, 16'd5));
    b1.motor_cmd = 4'b1111;
    wait_cyc(n + 1);
    check("start_busy", 32'(b1.busy), 32'h1);
    check("start_coil", 32'(b1.coil_out), 32'b0001);
    check("start_state", 32'(b1.dbg_state), 32'(RUN));

    // Stop and hold: 2 ticks of 4 cycles with the last pattern frozen
    wait_cyc(n + 21);
    b1.motor_cmd = 4'b1110;
    wait_cyc(n + 22);
    check("hold_state", 32'(b1.dbg_state), 32'(HOLD));
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(n + 22 + i);
      if (b1.busy !== 1'b1 || b1.coil_out !== 4'b1100) errs++;
    end
    check("hold_frozen_8", 32'(errs), 32'h0);
    wait_cyc(n + 30);
    check("hold_release_busy", 32'(b1.busy), 32'h0);
    check("hold_release_coil", 32'(b1.coil_out), 32'h0);

    // Resume from IDLE, then drop and re-raise run inside HOLD
    wait_cyc(n + 32);
    m = cyc;
    exp_q.push_back(ent(m + 5,  4'b1000, 16'd6));
    exp_q.push_back(ent(m + 12, 4'b1001, 16'd7));
    exp_q.push_back(ent(m + 16, 4'b0001, 16'd8));
    // dir toggled after the M+16 step: one more forward step, then reverse
    exp_q.push_back(ent(m + 20, 4'b0011, 16'd9));
    exp_q.push_back(ent(m + 24, 4'b0001, 16'd8));
    exp_q.push_back(ent(m + 28, 4'b1001, 16'd7));
    b1.motor_cmd = 4'b1111;
    wait_cyc(m + 5);
    b1.motor_cmd = 4'b1110;
    wait_cyc(m + 7);
    check("resume_hold_busy", 32'(b1.busy), 32'h1);
    check("resume_hold_coil", 32'(b1.coil_out), 32'b1000);
    b1.motor_cmd = 4'b1111;
    wait_cyc(m + 17);
    b1.motor_cmd = 4'b1101;
    wait_cyc(m + 28);
    b1.motor_cmd = 4'b0000;
    wait_cyc(m + 38);
    check("dirtog_idle_busy", 32'(b1.busy), 32'h0);

    // Asynchronous reset in the middle of a run, before its first step
    x = cyc;
    b1.motor_cmd = 4'b1111;
    wait_cyc(x + 3);
    check("prereset_busy", 32'(b1.busy), 32'h1);
    check("prereset_coil", 32'(b1.coil_out), 32'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_coil", 32'(b1.coil_out), 32'h0);
    check("async_rst_busy", 32'(b1.busy), 32'h0);
    check("async_rst_pos", 32'(b1.position), 32'h0);
    check("async_rst_state", 32'(b1.dbg_state), 32'(IDLE));
    b1.motor_cmd = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reverse at speed 0: P = 32
    r = cyc;
    exp_q.push_back(ent(r + 33, 4'b1001, 16'hFFFF));
    exp_q.push_back(ent(r + 65, 4'b1000, 16'hFFFE));
    b1.motor_cmd = 4'b0001;
    wait_cyc(r + 1);
    check("rev_start_coil", 32'(b1.coil_out), 32'b0001);
    wait_cyc(r + 65);
    b1.motor_cmd = 4'b0000;
    wait_cyc(r + 129);
    check("rev_hold_busy", 32'(b1.busy), 32'h1);
    wait_cyc(r + 130);
    check("rev_release_busy", 32'(b1.busy), 32'h0);
    check("rev_release_coil", 32'(b1.coil_out), 32'h0);

    // Full-step instance, one step per cycle, forward through the 0x7FFF->0x8000 wrap
    @(negedge clk);
    w = cyc;
    for (int k = 1; k <= 32768; k++) begin
      exp2_q.push_back(ent(w + 1 + k, fs_seq[k % 4], 16'(k)));
    end
    b2.motor_cmd = 4'b1111;
    wait_cyc(w + 1);
    check("fs_start_coil", 32'(b2.coil_out), 32'b0011);
    check("fs_start_busy", 32'(b2.busy), 32'h1);
    s = w + 1 + 32768;
    wait_cyc(s);
    check("wrap_pos_8000", 32'(b2.position), 32'h8000);
    b2.motor_cmd = 4'b1110;
    wait_cyc(s + 1);
    check("fs_hold_busy", 32'(b2.busy), 32'h1);
    check("fs_hold_coil", 32'(b2.coil_out), 32'b0011);
    check("fs_hold_pos", 32'(b2.position), 32'h8000);
    wait_cyc(s + 2);
    check("fs_hold0_busy", 32'(b2.busy), 32'h0);
    check("fs_hold0_coil", 32'(b2.coil_out), 32'h0);
    exp2_q.push_back(ent(s + 4, 4'b1001, 16'h7FFF));
    b2.motor_cmd = 4'b1101;
    wait_cyc(s + 4);
    b2.motor_cmd = 4'b0000;
    wait_cyc(s + 8);
    check("fs_final_busy", 32'(b2.busy), 32'h0);

    check("hs_queue_drained", 32'(exp_q.size()), 32'h0);
    check("fs_queue_drained", 32'(exp2_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
